// File: rtl/uart_tx_param.sv
// UART transmitter with run-time baud divisor, parity and stop-bit count, fed by a small FIFO.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             tx_data_in,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                          tx_break,
`endif
    output logic                          serial_out,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned IW = $clog2(DATA_W);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              push, pop, full, brk_block;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d, eff_div;
    logic [IW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d, stop_sec_q, stop_sec_d, done_q, done_d;

    assign full       = (level_q == LW'(FIFO_DEPTH));
    assign tx_ready   = !full;
    assign push       = tx_valid && !full;
    assign fifo_level = level_q;
    assign eff_div    = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
    assign tx_done    = done_q;
    assign busy       = (state_q != StIdle) || (level_q != '0) || brk_block;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data_in;
    end

`ifdef UART_TX_BREAK_EN
    logic             brk_q, brk_d;
    logic [DIV_W-1:0] brk_cnt_q, brk_cnt_d;

    // After break falls, brk_q keeps the line idle-high for one bit period.
    always_comb begin
        brk_d     = brk_q;
        brk_cnt_d = brk_cnt_q;
        if (tx_break && state_q == StIdle) begin
            brk_d     = 1'b1;
            brk_cnt_d = eff_div - 1'b1;
        end else if (brk_q && !tx_break) begin
            if (brk_cnt_q == '0) brk_d = 1'b0;
            else                 brk_cnt_d = brk_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_q     <= 1'b0;
            brk_cnt_q <= '0;
        end else begin
            brk_q     <= brk_d;
            brk_cnt_q <= brk_cnt_d;
        end
    end

    assign brk_block = tx_break || brk_q;
`else
    assign brk_block = 1'b0;
`endif

    always_comb begin
        logic load;
        load       = 1'b0;
        pop        = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_sec_d = stop_sec_q;
        done_d     = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = (cnt_q == '0) ? div_q - 1'b1 : cnt_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (level_q != '0 && !brk_block) load = 1'b1;
            end
            StStart: begin
                if (cnt_q == '0) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == IW'(DATA_W - 1)) begin
                        state_d    = par_en_q ? StParity : StStop;
                        stop_sec_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (cnt_q == '0) begin
                    state_d    = StStop;
                    stop_sec_d = 1'b0;
                end
            end
            StStop: begin
                if (cnt_q == '0) begin
                    if (stop2_q && !stop_sec_q) begin
                        stop_sec_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (level_q != '0 && !brk_block) load = 1'b1;
                        else                              state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame launch: pop head and freeze this frame's configuration.
        if (load) begin
            pop       = 1'b1;
            state_d   = StStart;
            shift_d   = mem_q[rd_ptr_q];
            div_d     = eff_div;
            cnt_d     = eff_div - 1'b1;
            par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_d = (^mem_q[rd_ptr_q]) ^ parity_mode[1];
            stop2_d   = stop2;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= DIV_W'(2);
            bit_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_sec_q <= stop_sec_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        serial_out = 1'b1;
        case (state_q)
            StStart:  serial_out = 1'b0;
            StData:   serial_out = shift_q[0];
            StParity: serial_out = par_bit_q;
            default:  serial_out = 1'b1;
        endcase
`ifdef UART_TX_BREAK_EN
        if (state_q == StIdle && tx_break) serial_out = 1'b0;
`endif
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: scoreboard-driven line receiver plus directed checks.
module tb_uart_tx_param;

    typedef struct {
        logic [8:0] data;
        int         nd;
        int         bc;
        logic [1:0] pm;
        logic       s2;
    } frame_t;

    logic        sys_clk, rst_n;
    logic [8:0]  tx_data;
    logic        tx_valid8, tx_valid7;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        tx_ready8, serial_out8, busy8, tx_done8;
    logic        tx_ready7, serial_out7, busy7, tx_done7;
    logic [2:0]  fifo_level8, fifo_level7;

    frame_t sb[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     done8_cnt = 0;
    int     fr = 0;
    bit     mon_on = 0;
    bit     mon_sel = 0;
    bit     in_frame = 0;
    bit     expect_b2b = 0;
    logic   last_done_busy;
    logic   mon_so, mon_done, mon_busy;

    assign mon_so   = mon_sel ? serial_out7 : serial_out8;
    assign mon_done = mon_sel ? tx_done7 : tx_done8;
    assign mon_busy = mon_sel ? busy7 : busy8;

    uart_tx_param #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) u_dut8 (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .tx_data_in  (tx_data[7:0]),
        .tx_valid    (tx_valid8),
        .tx_ready    (tx_ready8),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .serial_out  (serial_out8),
        .busy        (busy8),
        .tx_done     (tx_done8),
        .fifo_level  (fifo_level8)
    );

    uart_tx_param #(.DATA_W(7), .FIFO_DEPTH(4), .DIV_W(16)) u_dut7 (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .tx_data_in  (tx_data[6:0]),
        .tx_valid    (tx_valid7),
        .tx_ready    (tx_ready7),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .serial_out  (serial_out7),
        .busy        (busy7),
        .tx_done     (tx_done7),
        .fifo_level  (fifo_level7)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(negedge sys_clk) if (tx_done8 === 1'b1) done8_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || in_frame || busy8 || busy7) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 1);
        repeat (3) step();
    endtask

    // Receiver: expands each scoreboard entry into its bit sequence and checks every cycle.
    initial begin : monitor
        frame_t e;
        logic   bits[16];
        int     nb;
        logic   obs;
        forever begin
            @(negedge sys_clk);
            while (mon_on && mon_so === 1'b0) begin
                in_frame = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_start", 1, 0);
                    while (mon_so === 1'b0) @(negedge sys_clk);
                end else begin
                    e  = sb.pop_front();
                    nb = 0;
                    bits[nb] = 1'b0;
                    nb++;
                    for (int i = 0; i < e.nd; i++) begin
                        bits[nb] = e.data[i];
                        nb++;
                    end
                    if (e.pm == 2'b01 || e.pm == 2'b10) begin
                        bits[nb] = (^e.data) ^ e.pm[1];
                        nb++;
                    end
                    bits[nb] = 1'b1;
                    nb++;
                    if (e.s2) begin
                        bits[nb] = 1'b1;
                        nb++;
                    end
                    for (int b = 0; b < nb; b++) begin
                        obs = bits[b];
                        for (int c = 0; c < e.bc; c++) begin
                            if (b != 0 || c != 0) @(negedge sys_clk);
                            if (mon_so !== bits[b] && obs === bits[b]) obs = mon_so;
                            if (b == nb - 1 && c == e.bc - 1) chk("done_early", 32'(mon_done), 0);
                        end
                        chk($sformatf("frame%0d_bit%0d", fr, b), 32'(obs), 32'(bits[b]));
                    end
                    @(negedge sys_clk);
                    chk($sformatf("frame%0d_tx_done", fr), 32'(mon_done), 1);
                    last_done_busy = mon_busy;
                    if (expect_b2b && sb.size() > 0) chk("no_gap", 32'(mon_so), 0);
                    fr++;
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin : stim
        int d0, highs;
        rst_n = 1'b0;
        tx_data = '0;
        tx_valid8 = 1'b0;
        tx_valid7 = 1'b0;
        baud_div = 16'd4;
        parity_mode = 2'b01;
        stop2 = 1'b0;
        #12;
        chk("rst_serial", 32'(serial_out8), 1);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_ready", 32'(tx_ready8), 1);
        chk("rst_done", 32'(tx_done8), 0);
        chk("rst_level", 32'(fifo_level8), 0);
        step();
        rst_n = 1'b1;
        mon_on = 1'b1;
        step();

        // Even parity, 4-cycle bits, with launch latency checks.
        d0 = done8_cnt;
        sb.push_back('{9'h0AA, 8, 4, 2'b01, 1'b0});
        tx_data = 9'h0AA;
        tx_valid8 = 1'b1;
        step();
        tx_valid8 = 1'b0;
        chk("lat_level1", 32'(fifo_level8), 1);
        chk("lat_line_idle", 32'(serial_out8), 1);
        step();
        chk("lat_line_start", 32'(serial_out8), 0);
        chk("lat_level0", 32'(fifo_level8), 0);
        chk("lat_busy", 32'(busy8), 1);
        wait_drain(200);
        chk("t1_done_once", 32'(done8_cnt - d0), 1);
        chk("t1_busy_at_done", 32'(last_done_busy), 0);

        // Odd parity, two stop bits, 8-cycle bits.
        baud_div = 16'd8;
        parity_mode = 2'b10;
        stop2 = 1'b1;
        sb.push_back('{9'h0CC, 8, 8, 2'b10, 1'b1});
        tx_data = 9'h0CC;
        tx_valid8 = 1'b1;
        step();
        tx_valid8 = 1'b0;
        wait_drain(300);

        // Divisor 1 behaves as 2; parity mode 11 means no parity.
        baud_div = 16'd1;
        parity_mode = 2'b11;
        sb.push_back('{9'h03C, 8, 2, 2'b11, 1'b1});
        tx_data = 9'h03C;
        tx_valid8 = 1'b1;
        step();
        tx_valid8 = 1'b0;
        wait_drain(100);

        // FIFO fill: six write cycles, five accepted, frames back to back.
        baud_div = 16'd4;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        expect_b2b = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back('{9'(8'h31 + i), 8, 4, 2'b00, 1'b0});
        tx_valid8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = 9'(8'h31 + i);
            chk($sformatf("fill_ready%0d", i), 32'(tx_ready8), 32'(i < 5));
            step();
        end
        tx_valid8 = 1'b0;
        chk("fill_level", 32'(fifo_level8), 4);
        chk("fill_ready_low", 32'(tx_ready8), 0);
        wait_drain(400);
        expect_b2b = 1'b0;

        // Divisor change mid-frame only affects the next frame.
        sb.push_back('{9'h05A, 8, 4, 2'b00, 1'b0});
        sb.push_back('{9'h0A5, 8, 10, 2'b00, 1'b0});
        tx_data = 9'h05A;
        tx_valid8 = 1'b1;
        step();
        tx_data = 9'h0A5;
        step();
        tx_valid8 = 1'b0;
        repeat (8) step();
        baud_div = 16'd10;
        wait_drain(300);

        // Seven data bits, no parity.
        baud_div = 16'd4;
        mon_sel = 1'b1;
        sb.push_back('{9'h055, 7, 4, 2'b00, 1'b0});
        tx_data = 9'h055;
        tx_valid7 = 1'b1;
        step();
        tx_valid7 = 1'b0;
        wait_drain(100);
        chk("w7_line_high", 32'(serial_out7), 1);
        mon_sel = 1'b0;

        // Reset during data bit 3 with two words queued.
        mon_on = 1'b0;
        parity_mode = 2'b01;
        tx_data = 9'h000;
        tx_valid8 = 1'b1;
        repeat (3) step();
        tx_valid8 = 1'b0;
        repeat (16) step();
        chk("pre_rst_level", 32'(fifo_level8), 2);
        chk("pre_rst_line", 32'(serial_out8), 0);
        d0 = done8_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_line", 32'(serial_out8), 1);
        chk("mid_rst_level", 32'(fifo_level8), 0);
        chk("mid_rst_busy", 32'(busy8), 0);
        chk("mid_rst_ready", 32'(tx_ready8), 1);
        step();
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (serial_out8 === 1'b1 && busy8 === 1'b0) highs++;
        end
        chk("post_rst_quiet", 32'(highs), 200);
        chk("post_rst_no_done", 32'(done8_cnt - d0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
